// File: rtl/vit_pkg.sv
// Shared Viterbi decoder definitions: trellis sizing, state type, traceback
// FSM encoding and the block depth shared by the survivor memory and traceback.
package vit_pkg;

    localparam int unsigned NUM_ST   = 4;
    localparam int unsigned ST_W     = 2;
    localparam int unsigned TB_DEPTH = 8;

    typedef logic [ST_W-1:0] st_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACE  = 2'd1,
        OUTPUT = 2'd2
    } tb_fsm_t;

    // Trellis next = {u, s[1]}: the bit decoded for state s is its MSB.
    function automatic logic st_bit(input st_t s);
        return s[ST_W-1];
    endfunction

    // A predecessor p can reach s only if p's MSB became s's LSB.
    function automatic logic prv_legal(input st_t p, input st_t s);
        return p[ST_W-1] == s[0];
    endfunction

endpackage

// File: rtl/tb_lifo.sv
// Traceback bit stack: DEPTH x 1 push/pop LIFO with a registered top-of-stack.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr_i     empty the stack (priority over push/pop)
//   push_i    push din_i
//   din_i     bit to push
//   pop_i     discard the current top
//   top_o     registered copy of the current top (0 when empty)
module tb_lifo
    import vit_pkg::*;
#(
    parameter int unsigned DEPTH = TB_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic top_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [CW-1:0]    ptr_q, ptr_d;
    logic             top_q, top_d;

    // Next stack contents; top is kept as its own register so the output
    // never passes through the read mux.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        top_d = top_q;
        if (clr_i) begin
            ptr_d = '0;
            top_d = 1'b0;
        end else if (push_i) begin
            mem_d[AW'(ptr_q)] = din_i;
            ptr_d             = ptr_q + CW'(1);
            top_d             = din_i;
        end else if (pop_i) begin
            ptr_d = ptr_q - CW'(1);
            top_d = (ptr_q >= CW'(2)) ? mem_q[AW'(ptr_q - CW'(2))] : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            ptr_q <= '0;
            top_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            top_q <= top_d;
        end
    end

    assign top_o = top_q;

endmodule

// File: rtl/tb_unit.sv
// Viterbi traceback: starting from the best end state, follows the per-stage
// predecessor vectors played back by the survivor memory (newest stage first)
// for DEPTH stages, stacks the recovered bits and emits them in forward order.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   en_tb, end_state    start pulse (IDLE only) and best final state
//   bck_vld, bck_rdy    stage handshake from the survivor memory
//   bck_prv_st_00..11   predecessor of each state at the current stage
//   dec_bit, dec_vld    decoded bit stream, forward time order
//   dec_rdy             downstream accept
//   busy                FSM not idle
//   done                pulse on the handshake of the last bit of a block
//   tb_err              (only with TB_ERR_CHK_EN) sticky illegal-predecessor flag
// Optional feature macro: TB_ERR_CHK_EN
module tb_unit
    import vit_pkg::*;
#(
    parameter int unsigned DEPTH = TB_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_tb,
    input  logic [ST_W-1:0] end_state,
    input  logic            bck_vld,
    input  logic [ST_W-1:0] bck_prv_st_00,
    input  logic [ST_W-1:0] bck_prv_st_01,
    input  logic [ST_W-1:0] bck_prv_st_10,
    input  logic [ST_W-1:0] bck_prv_st_11,
    output logic            bck_rdy,
    output logic            dec_bit,
    output logic            dec_vld,
    input  logic            dec_rdy,
    output logic            busy,
    output logic            done
`ifdef TB_ERR_CHK_EN
    ,
    output logic            tb_err
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    tb_fsm_t       state_q, state_d;
    st_t           cur_st_q, cur_st_d;
    logic [CW-1:0] stg_cnt_q, stg_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic          bck_rdy_q, dec_vld_q, busy_q;
    st_t           prv_sel;
    logic          lifo_clr, lifo_push, lifo_pop, lifo_top;
    logic          done_c;
    logic          stage_take;

    // Predecessor of the registered current state.
    always_comb begin
        prv_sel = bck_prv_st_00;
        case (cur_st_q)
            2'b01:   prv_sel = bck_prv_st_01;
            2'b10:   prv_sel = bck_prv_st_10;
            2'b11:   prv_sel = bck_prv_st_11;
            default: prv_sel = bck_prv_st_00;
        endcase
    end

    assign stage_take = (state_q == TRACE) && bck_vld && bck_rdy_q;

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cur_st_d  = cur_st_q;
        stg_cnt_d = stg_cnt_q;
        out_cnt_d = out_cnt_q;
        lifo_clr  = 1'b0;
        lifo_push = 1'b0;
        lifo_pop  = 1'b0;
        done_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_tb) begin
                    state_d   = TRACE;
                    cur_st_d  = end_state;
                    stg_cnt_d = '0;
                    out_cnt_d = '0;
                    lifo_clr  = 1'b1;
                end
            end
            TRACE: begin
                if (stage_take) begin
                    lifo_push = 1'b1;
                    cur_st_d  = prv_sel;
                    stg_cnt_d = stg_cnt_q + CW'(1);
                    if (stg_cnt_q == CW'(DEPTH - 1)) begin
                        state_d = OUTPUT;
                    end
                end
            end
            OUTPUT: begin
                if (dec_vld_q && dec_rdy) begin
                    lifo_pop  = 1'b1;
                    out_cnt_d = out_cnt_q + CW'(1);
                    if (out_cnt_q == CW'(DEPTH - 1)) begin
                        done_c  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; handshake/status outputs are registered from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_st_q  <= '0;
            stg_cnt_q <= '0;
            out_cnt_q <= '0;
            bck_rdy_q <= 1'b0;
            dec_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_st_q  <= cur_st_d;
            stg_cnt_q <= stg_cnt_d;
            out_cnt_q <= out_cnt_d;
            bck_rdy_q <= (state_d == TRACE);
            dec_vld_q <= (state_d == OUTPUT);
            busy_q    <= (state_d != IDLE);
        end
    end

    tb_lifo #(
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (lifo_clr),
        .push_i (lifo_push),
        .din_i  (st_bit(cur_st_q)),
        .pop_i  (lifo_pop),
        .top_o  (lifo_top)
    );

`ifdef TB_ERR_CHK_EN
    logic err_q, err_d;

    // Sticky: cleared only when a new block is accepted.
    always_comb begin
        err_d = err_q;
        if ((state_q == IDLE) && en_tb) begin
            err_d = 1'b0;
        end else if (stage_take && !prv_legal(prv_sel, cur_st_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign tb_err = err_q;
`endif

    assign bck_rdy = bck_rdy_q;
    assign dec_vld = dec_vld_q;
    assign busy    = busy_q;
    assign dec_bit = lifo_top;
    // done must coincide with the final dec_rdy handshake, so it follows it.
    assign done    = done_c;

endmodule

// File: tb/tb_tb_unit.sv
// Bench for the Viterbi traceback stage: table of predecessor/end-state
// vectors with expected forward bit sequences, scoreboard of expected bits,
// plus a reset-mid-trace sequence.
module tb_tb_unit;

    logic       clk;
    logic       rst;
    logic       en_tb;
    logic [1:0] end_state;
    logic       bck_vld;
    logic [1:0] bck_prv_st_00, bck_prv_st_01, bck_prv_st_10, bck_prv_st_11;
    logic       bck_rdy;
    logic       dec_bit;
    logic       dec_vld;
    logic       dec_rdy;
    logic       busy;
    logic       done;
`ifdef TB_ERR_CHK_EN
    logic       tb_err;
`endif

    tb_unit #(
        .DEPTH (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en_tb         (en_tb),
        .end_state     (end_state),
        .bck_vld       (bck_vld),
        .bck_prv_st_00 (bck_prv_st_00),
        .bck_prv_st_01 (bck_prv_st_01),
        .bck_prv_st_10 (bck_prv_st_10),
        .bck_prv_st_11 (bck_prv_st_11),
        .bck_rdy       (bck_rdy),
        .dec_bit       (dec_bit),
        .dec_vld       (dec_vld),
        .dec_rdy       (dec_rdy),
        .busy          (busy),
        .done          (done)
`ifdef TB_ERR_CHK_EN
        ,
        .tb_err        (tb_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] end_st;
        logic [1:0] p00, p01, p10, p11;
        logic [7:0] exp_bits;   // MSB is the first bit out
        logic       exp_err;
        logic       stall_tr;
        logic       stall_out;
        logic       spam;
    } vec_t;

    vec_t vecs[6];
    logic sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic [1:0] e, input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] c, input logic [1:0] d, input logic [7:0] x,
                                input logic er, input logic st, input logic so, input logic sp);
        vec_t v;
        v.end_st = e; v.p00 = a; v.p01 = b; v.p10 = c; v.p11 = d;
        v.exp_bits = x; v.exp_err = er; v.stall_tr = st; v.stall_out = so; v.spam = sp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Runs one block; abort_n>0 asserts reset after that many consumes.
    task automatic run_block(input int idx, input int abort_n);
        vec_t v;
        int   consumed, trace_cyc, nbits, stall_cnt, guard;
        logic phase, consume, expb;
        v = vecs[idx];
        end_state     = v.end_st;
        bck_prv_st_00 = v.p00;
        bck_prv_st_01 = v.p01;
        bck_prv_st_10 = v.p10;
        bck_prv_st_11 = v.p11;
        bck_vld       = 1'b0;
        dec_rdy       = 1'b1;
        en_tb         = 1'b1;
        for (int i = 0; i < 8; i++) sb.push_back(v.exp_bits[7-i]);
        @(posedge clk); #1;
        en_tb = v.spam;
        chk("busy_start", busy, 1);
        chk("bck_rdy_latency", bck_rdy, 1);
        chk("dec_vld_in_trace", dec_vld, 0);
`ifdef TB_ERR_CHK_EN
        chk("tb_err_cleared", tb_err, 0);
`endif
        consumed  = 0;
        trace_cyc = 0;
        phase     = 1'b1;
        guard     = 0;
        while (!dec_vld && guard < 100) begin
            if (bck_rdy) trace_cyc++;
            bck_vld = v.stall_tr ? phase : 1'b1;
            phase   = ~phase;
            consume = bck_vld && bck_rdy;
            @(posedge clk); #1;
            guard++;
            if (consume) begin
                consumed++;
`ifdef TB_ERR_CHK_EN
                if (consumed == 1) chk("tb_err_first", tb_err, 32'(v.exp_err));
`endif
                if (consumed == abort_n) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_bck_rdy", bck_rdy, 0);
                    chk("rst_dec_vld", dec_vld, 0);
                    chk("rst_dec_bit", dec_bit, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_done", done, 0);
`ifdef TB_ERR_CHK_EN
                    chk("rst_tb_err", tb_err, 0);
`endif
                    sb.delete();
                    bck_vld = 1'b0;
                    en_tb   = 1'b0;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    @(posedge clk); #1;
                    chk("post_rst_busy", busy, 0);
                    return;
                end
            end
        end
        bck_vld = 1'b0;
        if (guard >= 100) fail_now("trace_timeout");
        chk("trace_consumes", consumed, 8);
        chk("trace_cycles", trace_cyc, v.stall_tr ? 15 : 8);
        chk("bck_rdy_dropped", bck_rdy, 0);

        nbits     = 0;
        stall_cnt = 0;
        guard     = 0;
        while (busy && guard < 100) begin
            dec_rdy = !(v.stall_out && nbits == 3 && stall_cnt < 3);
            if (!dec_rdy) stall_cnt++;
            #1;
            chk("dec_vld_out", dec_vld, 1);
            if (dec_rdy) begin
                if (sb.size() == 0) begin
                    fail_now("extra_output_bit");
                end else begin
                    expb = sb.pop_front();
                    chk($sformatf("dec_bit[%0d]", nbits), dec_bit, 32'(expb));
                    chk("done_pulse", done, 32'(sb.size() == 0));
                end
                nbits++;
            end else begin
                if (sb.size() != 0) chk("dec_bit_stalled", dec_bit, 32'(sb[0]));
                chk("done_stalled", done, 0);
            end
            @(posedge clk); #1;
            guard++;
        end
        en_tb   = 1'b0;
        dec_rdy = 1'b1;
        if (guard >= 100) fail_now("output_timeout");
        chk("bits_out", nbits, 8);
        chk("sb_empty", sb.size(), 0);
        chk("idle_dec_vld", dec_vld, 0);
        chk("idle_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("still_idle", busy, 0);
`ifdef TB_ERR_CHK_EN
        chk("tb_err_sticky", tb_err, 32'(v.exp_err));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(2'b00, 2'b01, 2'b10, 2'b01, 2'b11, 8'b0101_0100, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1] = mk(2'b11, 2'b01, 2'b10, 2'b01, 2'b11, 8'b1111_1111, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2] = mk(2'b00, 2'b01, 2'b10, 2'b01, 2'b11, 8'b0101_0100, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[3] = mk(2'b00, 2'b01, 2'b10, 2'b01, 2'b11, 8'b0101_0100, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[4] = mk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 8'b0000_0001, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[5] = mk(2'b01, 2'b00, 2'b10, 2'b01, 2'b11, 8'b1010_1010, 1'b0, 1'b0, 1'b0, 1'b0);

        rst           = 1'b1;
        en_tb         = 1'b0;
        end_state     = 2'b00;
        bck_vld       = 1'b0;
        bck_prv_st_00 = 2'b00;
        bck_prv_st_01 = 2'b00;
        bck_prv_st_10 = 2'b00;
        bck_prv_st_11 = 2'b00;
        dec_rdy       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bck_rdy", bck_rdy, 0);
        chk("reset_dec_vld", dec_vld, 0);
        chk("reset_dec_bit", dec_bit, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
`ifdef TB_ERR_CHK_EN
        chk("reset_tb_err", tb_err, 0);
`endif
        rst = 1'b0;

        // Stage data offered while idle must not start anything.
        bck_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ignores_bck", busy, 0);
        chk("idle_bck_rdy", bck_rdy, 0);
        bck_vld = 1'b0;

        for (int i = 0; i < 6; i++) run_block(i, 0);

        // Reset after the 4th consume, then a fresh block decodes cleanly.
        run_block(1, 4);
        run_block(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
